// File: rtl/rsa_modexp.sv
// Montgomery modular exponentiation c = m^e mod p with a bit-serial MM datapath.
// Optional build macro RSA_SKIP_LEADING_ZEROS_EN starts the square/multiply loop at the MSB of e.
module rsa_modexp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             start_cmd,
  input  logic             stop_cmd,
  input  logic [WIDTH-1:0] rsa_p,
  input  logic [WIDTH-1:0] rsa_e,
  input  logic [WIDTH-1:0] rsa_m,
  input  logic [WIDTH-1:0] rsa_const,
  output logic [WIDTH-1:0] rsa_c,
  output logic             eoc,
  output logic             busy
);

  localparam int SW = WIDTH + 2;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE_M, S_PRE_X, S_SQUARE, S_MULT, S_POST, S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] p_q, e_q, m_q, const_q, mbar_q, xbar_q, rsa_c_q;
  logic [SW-1:0]    s_q;
  logic [CW-1:0]    step_q;
  logic [BW-1:0]    bit_q;
  logic             eoc_q, busy_q;

  logic [WIDTH-1:0] a_s, b_s, mm_res_d;
  logic             a_bit_s;
  logic [SW-1:0]    acc_s, odd_s, s_step_d, s_corr_s, p_ext_s;
  logic [BW-1:0]    start_bit_d;

`ifdef RSA_SKIP_LEADING_ZEROS_EN
  function automatic logic [BW-1:0] msb_pos(input logic [WIDTH-1:0] v);
    logic [BW-1:0] pos;
    pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) pos = BW'(i);
    end
    return pos;
  endfunction
  assign start_bit_d = msb_pos(rsa_e);
`else
  assign start_bit_d = BW'(WIDTH - 1);
`endif

  // Operand selection for the Montgomery product of the current state
  always_comb begin
    a_s = '0;
    b_s = '0;
    case (state_q)
      S_PRE_M:  begin a_s = m_q;    b_s = const_q; end
      S_PRE_X:  begin a_s = ONE;    b_s = const_q; end
      S_SQUARE: begin a_s = xbar_q; b_s = xbar_q;  end
      S_MULT:   begin a_s = mbar_q; b_s = xbar_q;  end
      S_POST:   begin a_s = xbar_q; b_s = ONE;     end
      default:  begin a_s = '0;     b_s = '0;      end
    endcase
  end

  // One MM iteration and the final conditional subtraction
  always_comb begin
    p_ext_s  = {2'b00, p_q};
    a_bit_s  = (step_q < LAST_STEP) ? a_s[step_q[BW-1:0]] : 1'b0;
    acc_s    = s_q + (a_bit_s ? {2'b00, b_s} : {SW{1'b0}});
    odd_s    = acc_s[0] ? (acc_s + p_ext_s) : acc_s;
    s_step_d = odd_s >> 1;
    s_corr_s = (s_q >= p_ext_s) ? (s_q - p_ext_s) : s_q;
    mm_res_d = s_corr_s[WIDTH-1:0];
  end

  // Control FSM, operand shadows, MM accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      p_q <= '0; e_q <= '0; m_q <= '0; const_q <= '0;
      mbar_q <= '0; xbar_q <= '0; rsa_c_q <= '0;
      s_q <= '0; step_q <= '0; bit_q <= '0;
      eoc_q <= 1'b0; busy_q <= 1'b0;
    end else if (ena) begin
      if (state_q == S_IDLE) begin
        eoc_q <= 1'b0;
        if (start_cmd && !stop_cmd) begin
          p_q <= rsa_p; e_q <= rsa_e; m_q <= rsa_m; const_q <= rsa_const;
          s_q <= '0; step_q <= '0; bit_q <= start_bit_d;
          busy_q  <= 1'b1;
          state_q <= S_PRE_M;
        end else begin
          busy_q <= 1'b0;
        end
      end else if (stop_cmd || state_q == S_DONE) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        eoc_q   <= 1'b0;
        s_q     <= '0;
        step_q  <= '0;
      end else if (step_q != LAST_STEP) begin
        s_q    <= s_step_d;
        step_q <= step_q + CW'(1);
      end else begin
        s_q    <= '0;
        step_q <= '0;
        case (state_q)
          S_PRE_M: begin
            mbar_q  <= mm_res_d;
            state_q <= S_PRE_X;
          end
          S_PRE_X: begin
            xbar_q <= mm_res_d;
`ifdef RSA_SKIP_LEADING_ZEROS_EN
            state_q <= (e_q == '0) ? S_POST : S_SQUARE;
`else
            state_q <= S_SQUARE;
`endif
          end
          S_SQUARE: begin
            xbar_q <= mm_res_d;
            if (e_q[bit_q]) begin
              state_q <= S_MULT;
            end else if (bit_q == '0) begin
              state_q <= S_POST;
            end else begin
              bit_q   <= bit_q - BW'(1);
              state_q <= S_SQUARE;
            end
          end
          S_MULT: begin
            xbar_q <= mm_res_d;
            if (bit_q == '0) begin
              state_q <= S_POST;
            end else begin
              bit_q   <= bit_q - BW'(1);
              state_q <= S_SQUARE;
            end
          end
          S_POST: begin
            rsa_c_q <= mm_res_d;
            eoc_q   <= 1'b1;
            state_q <= S_DONE;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rsa_c = rsa_c_q;
  assign eoc   = eoc_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_rsa_modexp.sv
// Directed bench for rsa_modexp: results, latency, abort, enable freeze and reset mid-run.
module tb_rsa_modexp;
  localparam int W = 8;

`ifdef RSA_SKIP_LEADING_ZEROS_EN
  localparam int L17 = 91, L0 = 28, L1 = 46, L2 = 55;
`else
  localparam int L17 = 118, L0 = 100, L1 = 109, L2 = 109;
`endif

  logic         clk = 1'b0;
  logic         rstb, ena, start_cmd, stop_cmd;
  logic [W-1:0] rsa_p, rsa_e, rsa_m, rsa_const, rsa_c;
  logic         eoc, busy;

  int checks   = 0;
  int failures = 0;

  rsa_modexp #(.WIDTH(W)) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .start_cmd(start_cmd), .stop_cmd(stop_cmd),
    .rsa_p(rsa_p), .rsa_e(rsa_e), .rsa_m(rsa_m), .rsa_const(rsa_const),
    .rsa_c(rsa_c), .eoc(eoc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Start a run at the next falling edge; on return the bench is in cycle 1.
  task automatic kick(input int e, input int m);
    @(negedge clk);
    rsa_p = 8'd61; rsa_const = 8'd22; rsa_e = W'(e); rsa_m = W'(m);
    start_cmd = 1'b1;
    @(negedge clk);
    start_cmd = 1'b0;
  endtask

  task automatic run_vec(input string tag, input int e, input int m,
                         input int exp_c, input int exp_lat);
    int cyc;
    int low_seen;
    kick(e, m);
    cyc = 1;
    low_seen = 0;
    check({tag, "_busy_rise"}, int'(busy), 1);
    while (!eoc && cyc < 400) begin
      if (!busy) low_seen++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_result"}, int'(rsa_c), exp_c);
    check({tag, "_busy_gap"}, low_seen, 0);
    check({tag, "_busy_at_eoc"}, int'(busy), 1);
    @(negedge clk);
    check({tag, "_busy_fall"}, int'(busy), 0);
    check({tag, "_eoc_single"}, int'(eoc), 0);
  endtask

  initial begin
    int cyc;
    int eoc_seen;
    rstb = 1'b0; ena = 1'b1; start_cmd = 1'b0; stop_cmd = 1'b0;
    rsa_p = '0; rsa_e = '0; rsa_m = '0; rsa_const = '0;
    repeat (3) @(negedge clk);
    check("reset_c", int'(rsa_c), 0);
    check("reset_eoc", int'(eoc), 0);
    check("reset_busy", int'(busy), 0);
    rstb = 1'b1;

    run_vec("v17", 17, 5, 36, L17);
    run_vec("e0", 0, 5, 1, L0);
    run_vec("m0", 1, 0, 0, L1);
    run_vec("m60", 2, 60, 1, L2);
    run_vec("v17b", 17, 5, 36, L17);

    // Abort at cycle 50
    kick(17, 5);
    cyc = 1;
    while (cyc < 50) begin @(negedge clk); cyc++; end
    stop_cmd = 1'b1;
    @(negedge clk);
    stop_cmd = 1'b0;
    check("stop_busy", int'(busy), 0);
    check("stop_eoc", int'(eoc), 0);
    eoc_seen = 0;
    repeat (150) begin @(negedge clk); if (eoc) eoc_seen++; end
    check("stop_no_eoc", eoc_seen, 0);
    check("stop_c_kept", int'(rsa_c), 36);
    run_vec("after_stop", 17, 5, 36, L17);

    // Stop and start together in IDLE: stop wins
    @(negedge clk);
    start_cmd = 1'b1; stop_cmd = 1'b1;
    @(negedge clk);
    start_cmd = 1'b0; stop_cmd = 1'b0;
    check("start_stop_idle", int'(busy), 0);

    // Enable low for 20 cycles, a second start and a changed message mid-run
    rsa_c_clear_free: begin end
    kick(17, 5);
    cyc = 1;
    while (!eoc && cyc < 400) begin
      start_cmd = (cyc == 10);
      if (cyc == 10) rsa_m = 8'd7;
      if (cyc == 30) ena = 1'b0;
      if (cyc == 50) ena = 1'b1;
      @(negedge clk);
      cyc++;
    end
    start_cmd = 1'b0;
    check("ena_latency", cyc, L17 + 20);
    check("ena_result", int'(rsa_c), 36);
    @(negedge clk);
    check("ena_busy_fall", int'(busy), 0);

    // Reset pulse at cycle 60
    kick(17, 5);
    cyc = 1;
    while (cyc < 60) begin @(negedge clk); cyc++; end
    rstb = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    check("rst_c", int'(rsa_c), 0);
    check("rst_eoc", int'(eoc), 0);
    check("rst_busy", int'(busy), 0);
    eoc_seen = 0;
    repeat (200) begin @(negedge clk); if (eoc || busy) eoc_seen++; end
    check("rst_no_eoc", eoc_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rsa_modexp.md
# rsa_modexp

Montgomery modular-exponentiation engine that computes c = m^e mod p. It sits directly downstream of the SPI register bank. It takes p, e, m, the Montgomery constant and the start/stop command pulses from that bank. It returns the ciphertext and an end-of-conversion pulse, which the bank captures into its C register and status bit.

## Interface
- WIDTH, 8, operand width in bits; Montgomery radix R = 2^WIDTH.
- clk  input  1  system clock; all logic on rising edge.
- rstb  input  1  reset, synchronous and active-low.
- ena  input  1  global enable; when low every register holds its value.
- start_cmd  input  1  single-cycle start pulse.
- stop_cmd  input  1  single-cycle abort pulse.
- rsa_p  input  WIDTH  modulus; must be odd and greater than 1.
- rsa_e  input  WIDTH  exponent.
- rsa_m  input  WIDTH  message; must be less than p.
- rsa_const  input  WIDTH  R^2 mod p, supplied by software.
- rsa_c  output  WIDTH  result register.
- eoc  output  1  one-cycle pulse; rsa_c is valid in the same cycle.
- busy  output  1  high in every state except IDLE.

## Operation
- Reset values: rsa_c=0, eoc=0, busy=0, FSM in IDLE.
- IDLE + start_cmd (ena=1, stop_cmd=0): latch p, e, m and const into internal shadow registers. SPI writes during a run have no effect on that run.
- Sequence of Montgomery products MM(a,b) = a·b·R⁻¹ mod p:
  - PRE_M: mbar = MM(m, const).
  - PRE_X: xbar = MM(1, const).
  - For each bit i from WIDTH-1 down to 0:
    - SQUARE: xbar = MM(xbar, xbar).
    - MULT: xbar = MM(mbar, xbar). Entered only if e[i]=1.
  - POST: result = MM(xbar, 1).
  - DONE.
- MM datapath is bit-serial over the bits of a, LSB first:
  - Each step: S = S + a_i·b; if S is odd, S = S + p; then S = S >> 1.
  - After WIDTH steps, one correction cycle: if S ≥ p, S = S − p.
  - S is WIDTH+2 bits wide. Invariant: S < 2p before correction.
- DONE lasts one cycle. In that cycle rsa_c is loaded with the result and eoc=1. Next state is IDLE.
- stop_cmd in any non-IDLE state: go to IDLE on the next cycle. No eoc is produced, rsa_c keeps its previous value, and partial results are discarded.
- start_cmd in any non-IDLE state is ignored.
- start_cmd and stop_cmd together in IDLE: stop wins; the block stays in IDLE.
- Illegal operands (even p, p<2, m≥p): result is undefined. Latency must still match the formula in Timing; the FSM must never hang.
- Reset asserted mid-run: FSM returns to IDLE and all outputs return to their reset values on the next edge.

## Timing
- Every MM state occupies exactly WIDTH+1 enabled cycles: WIDTH iteration cycles plus 1 correction cycle. A step counter runs 0..WIDTH.
- Number of products: N = 3 + K + popcount(e). K is the number of squarings: WIDTH by default (see Configuration).
- Cycle 0 is the cycle in which start_cmd is sampled.
  - busy rises at cycle 1.
  - eoc is asserted at cycle N·(WIDTH+1) + 1.
  - busy falls at cycle N·(WIDTH+1) + 2.
- ena=0 freezes the FSM, counters and datapath. A run delayed by D disabled cycles completes exactly D cycles later.
- start_cmd and stop_cmd are ignored while ena=0.

## Configuration
- RSA_SKIP_LEADING_ZEROS_EN defined:
  - At start, a priority encoder finds the MSB position k of e, and the bit loop begins at k.
  - Leading-zero squarings cost zero cycles, so K = k+1.
  - For e=0, K=0: only PRE_M, PRE_X and POST run, and the result is 1.
  - Results are identical to the default build; only latency changes.
- Not defined: the loop always starts at bit WIDTH-1, K = WIDTH, and latency depends only on popcount(e).

## Test plan
- WIDTH=8, p=61, const=22, m=5, e=17, start pulse -> rsa_c=36 with eoc at cycle 118 (macro off) or cycle 91 (macro on); busy high from cycle 1 through the eoc cycle.
- Same p and const, m=5, e=0 -> rsa_c=1; eoc at cycle 100 (off) or cycle 28 (on).
- p=61, const=22, m=0, e=1 -> rsa_c=0. Then m=60, e=2 -> rsa_c=1.
- Run the first vector to completion (rsa_c=36). Rerun it and pulse stop_cmd at cycle 50 -> busy low at cycle 51, no eoc, rsa_c stays 36. A fresh start then yields 36 at the nominal latency.
- First vector with ena held low for 20 cycles mid-run, plus a second start_cmd pulse and changed rsa_m during the run -> rsa_c=36, eoc exactly 20 cycles late, second start ignored.
- rstb low for one cycle at cycle 60 of a run -> next cycle rsa_c=0, eoc=0, busy=0. No eoc appears afterwards without a new start.
